timer_bank: RTL and testbench

// - N-channel timekeeping core: each channel is an hh:mm:ss counter that counts up (stopwatch) or down (countdown timer).
// - Generalises the single stopwatch into a parametrised bank, adding per-channel direction, preset load, expiry and lap-hold display.
// - Sits between the debounced key/switch logic and the BIN2BCD/7-segment display path, clocked by the 100 Hz clock.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_bank_if.sv | 36 +++
 rtl/timer_channel.sv | 103 ++++++++++
 rtl/timer_bank.sv | 114 +++++++++++
 tb/tb_timer_bank.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants, channel state encoding and the hh:mm:ss value type for the timer bank.
package timer_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } hms_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Key/preset inputs and display/status outputs of the timer bank.
interface timer_bank_if #(
  parameter int N_CH = 4
);
  import timer_pkg::*;

  localparam int CW = clog2(N_CH);

  logic            FAST;
  logic [CW-1:0]   CH_SEL;
  logic            START;
  logic            CLEAR;
  logic            LOAD;
  logic            LD_DOWN;
  logic [5:0]      LD_SEC;
  logic [5:0]      LD_MIN;
  logic [4:0]      LD_HOUR;
  logic            LAP;
  logic [5:0]      SECOND;
  logic [5:0]      MINUTE;
  logic [4:0]      HOUR;
  logic [N_CH-1:0] RUNNING;
  logic [N_CH-1:0] EXPIRED;
  logic            TICK;

  modport master (
    output FAST, CH_SEL, START, CLEAR, LOAD, LD_DOWN, LD_SEC, LD_MIN, LD_HOUR, LAP,
    input  SECOND, MINUTE, HOUR, RUNNING, EXPIRED, TICK
  );

  modport slave (
    input  FAST, CH_SEL, START, CLEAR, LOAD, LD_DOWN, LD_SEC, LD_MIN, LD_HOUR, LAP,
    output SECOND, MINUTE, HOUR, RUNNING, EXPIRED, TICK
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: run/stop/done FAMILY FSM plus hh:mm:ss up/down counter.
//   state   | meaning
//   ST_STOP | paused or idle, value held
//   ST_RUN  | value advances on each tick in the loaded direction
//   ST_DONE | countdown reached zero; only clear/load leave
module timer_channel
  import timer_pkg::*;
#(
  parameter int HOUR_MAX = 24
) (
  input  logic       CLK100,
  input  logic       RST,
  input  logic       tick,
  input  logic       start,
  input  logic       clear,
  input  logic       load,
  input  logic       ld_down,
  input  logic [5:0] ld_sec,
  input  logic [5:0] ld_min,
  input  logic [4:0] ld_hour,
  output hms_t       value,
  output ch_state_t  state
);

  ch_state_t state_nx;
  hms_t      value_nx;
  hms_t      ld_sat;
  logic      down;
  logic      down_nx;
  logic      at_zero;
  logic      at_one;

  assign at_zero = (value == '0);
  assign at_one  = (value.hour == '0) && (value.min == '0) && (value.sec == 6'd1);

  always_comb begin
    ld_sat      = '0;
    ld_sat.sec  = (ld_sec > 6'(SEC_MAX)) ? 6'(SEC_MAX) : ld_sec;
    ld_sat.min  = (ld_min > 6'(MIN_MAX)) ? 6'(MIN_MAX) : ld_min;
    ld_sat.hour = (ld_hour > 5'(HOUR_MAX - 1)) ? 5'(HOUR_MAX - 1) : ld_hour;
  end

  always_comb begin
    state_nx = state;
    value_nx = value;
    down_nx  = down;
    if (clear) begin
      state_nx = ST_STOP;
      value_nx = '0;
    end else if (load) begin
      state_nx = ST_STOP;
      value_nx = ld_sat;
      down_nx  = ld_down;
    end else if (start) begin
      case (state)
        ST_STOP: if (!(down && at_zero)) state_nx = ST_RUN;
        ST_RUN:  state_nx = ST_STOP;
        default: ;
      endcase
    end else if (tick && (state == ST_RUN)) begin
      if (!down) begin
        if (value.sec == 6'(SEC_MAX)) begin
          value_nx.sec = '0;
          if (value.min == 6'(MIN_MAX)) begin
            value_nx.min  = '0;
            value_nx.hour = (value.hour == 5'(HOUR_MAX - 1)) ? '0 : value.hour + 5'd1;
          end else begin
            value_nx.min = value.min + 6'd1;
          end
        end else begin
          value_nx.sec = value.sec + 6'd1;
        end
      end else if (at_one || at_zero) begin
        // Expiry lands on the same edge that would have shown 00:00:00.
        value_nx = '0;
        state_nx = ST_DONE;
      end else if (value.sec != '0) begin
        value_nx.sec = value.sec - 6'd1;
      end else begin
        value_nx.sec = 6'(SEC_MAX);
        if (value.min != '0) begin
          value_nx.min = value.min - 6'd1;
        end else begin
          value_nx.min  = 6'(MIN_MAX);
          value_nx.hour = value.hour - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK100) begin
    if (RST) begin
      state <= ST_STOP;
      value <= '0;
      down  <= 1'b0;
    end else begin
      state <= state_nx;
      value <= value_nx;
      down  <= down_nx;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// N-channel hh:mm:ss timer bank: 1 s prescaler, key demux, lap hold and registered display.
module timer_bank
  import timer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 100,
  parameter int HOUR_MAX = 24
) (
  input logic         CLK100,
  input logic         RST,
  timer_bank_if.slave bus
);

  localparam int CW = clog2(N_CH);
  localparam int PW = clog2(TICK_DIV + 1);

  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic            sel_ok;
  hms_t            ch_value [N_CH];
  ch_state_t       ch_state [N_CH];
  hms_t            live;
  logic            hold;
  logic            hold_nx;
  hms_t            hold_val;
  hms_t            hold_val_nx;
  hms_t            disp_nx;
  logic [CW-1:0]   sel_q;
  logic [N_CH-1:0] run_nx;
  logic [N_CH-1:0] exp_nx;

  assign tick   = bus.FAST || (pre_cnt == PW'(TICK_DIV - 1));
  assign sel_ok = (32'(bus.CH_SEL) < N_CH);

  always_ff @(posedge CLK100) begin
    if (RST) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = sel_ok && (bus.CH_SEL == CW'(i));

    timer_channel #(.HOUR_MAX(HOUR_MAX)) u_ch (
      .CLK100  (CLK100),
      .RST     (RST),
      .tick    (tick),
      .start   (bus.START && hit),
      .clear   (bus.CLEAR && hit),
      .load    (bus.LOAD && hit),
      .ld_down (bus.LD_DOWN),
      .ld_sec  (bus.LD_SEC),
      .ld_min  (bus.LD_MIN),
      .ld_hour (bus.LD_HOUR),
      .value   (ch_value[i]),
      .state   (ch_state[i])
    );
  end

  always_comb begin
    live = '0;
    if (sel_ok) live = ch_value[bus.CH_SEL];
  end

  // Hold always belongs to sel_q; any selection change drops it before it could show the wrong channel.
  always_comb begin
    hold_nx     = hold;
    hold_val_nx = hold_val;
    if (bus.CH_SEL != sel_q) begin
      hold_nx = 1'b0;
    end else if (sel_ok && (bus.CLEAR || bus.LOAD)) begin
      hold_nx = 1'b0;
    end else if (sel_ok && bus.LAP) begin
      hold_nx = !hold;
      if (!hold) hold_val_nx = live;
    end
    disp_nx = hold_nx ? hold_val_nx : live;
  end

  always_comb begin
    run_nx = '0;
    exp_nx = '0;
    for (int i = 0; i < N_CH; i++) begin
      run_nx[i] = (ch_state[i] == ST_RUN);
      exp_nx[i] = (ch_state[i] == ST_DONE);
    end
  end

  always_ff @(posedge CLK100) begin
    if (RST) begin
      hold        <= 1'b0;
      hold_val    <= '0;
      sel_q       <= '0;
      bus.SECOND  <= '0;
      bus.MINUTE  <= '0;
      bus.HOUR    <= '0;
      bus.RUNNING <= '0;
      bus.EXPIRED <= '0;
      bus.TICK    <= 1'b0;
    end else begin
      hold        <= hold_nx;
      hold_val    <= hold_val_nx;
      sel_q       <= bus.CH_SEL;
      bus.SECOND  <= disp_nx.sec;
      bus.MINUTE  <= disp_nx.min;
      bus.HOUR    <= disp_nx.hour;
      bus.RUNNING <= run_nx;
      bus.EXPIRED <= exp_nx;
      bus.TICK    <= tick;
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: stimulus queues timed expectations, a negedge monitor checks them.
module tb_timer_bank;
  import timer_pkg::*;

  localparam int N_CH = 4;

  typedef struct {
    string      name;
    int         due;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [3:0] run;
    logic [3:0] exp;
    logic       tick;
  } exp_t;

  logic CLK100 = 1'b0;
  logic RST;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb [$];
  exp_t m_e;

  always #5 CLK100 = ~CLK100;
  always @(posedge CLK100) cyc <= cyc + 1;

  timer_bank_if #(.N_CH(N_CH)) bus ();

  timer_bank #(.N_CH(N_CH), .TICK_DIV(100), .HOUR_MAX(24)) dut (
    .CLK100 (CLK100),
    .RST    (RST),
    .bus    (bus)
  );

  task automatic expect_at(input string name, input int due, input int hh, input int mm,
                           input int ss, input logic [3:0] run, input logic [3:0] exp,
                           input logic tick);
    exp_t e;
    e.name = name;
    e.due  = due;
    e.hour = 5'(hh);
    e.min  = 6'(mm);
    e.sec  = 6'(ss);
    e.run  = run;
    e.exp  = exp;
    e.tick = tick;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge CLK100);
  endtask

  task automatic pulse_keys(input int t, input logic st, input logic cl, input logic ld,
                            input logic lp);
    wait_to(t);
    bus.START = st;
    bus.CLEAR = cl;
    bus.LOAD  = ld;
    bus.LAP   = lp;
    wait_to(t + 1);
    bus.START = 1'b0;
    bus.CLEAR = 1'b0;
    bus.LOAD  = 1'b0;
    bus.LAP   = 1'b0;
  endtask

  always @(negedge CLK100) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      m_e = sb.pop_front();
      checks++;
      if (bus.HOUR !== m_e.hour || bus.MINUTE !== m_e.min || bus.SECOND !== m_e.sec ||
          bus.RUNNING !== m_e.run || bus.EXPIRED !== m_e.exp || bus.TICK !== m_e.tick) begin
        failures++;
        $display("FAIL %s @%0d: got %0d:%0d:%0d run=%b exp=%b tick=%b, want %0d:%0d:%0d run=%b exp=%b tick=%b",
                 m_e.name, cyc, bus.HOUR, bus.MINUTE, bus.SECOND, bus.RUNNING, bus.EXPIRED,
                 bus.TICK, m_e.hour, m_e.min, m_e.sec, m_e.run, m_e.exp, m_e.tick);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: stuck at cycle %0d, want finish by 4160", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    RST         = 1'b1;
    bus.FAST    = 1'b1;
    bus.CH_SEL  = '0;
    bus.START   = 1'b0;
    bus.CLEAR   = 1'b0;
    bus.LOAD    = 1'b0;
    bus.LAP     = 1'b0;
    bus.LD_DOWN = 1'b0;
    bus.LD_SEC  = '0;
    bus.LD_MIN  = '0;
    bus.LD_HOUR = '0;

    expect_at("reset",        2, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
    expect_at("reset_rel",    4, 0, 0, 0, 4'b0000, 4'b0000, 1'b1);
    wait_to(3);
    RST = 1'b0;

    // ch0 up count in fast mode; START with tick applies no count
    expect_at("a_start_noinc", 7,    0, 0, 0, 4'b0001, 4'b0000, 1'b1);
    expect_at("a_first_inc",   8,    0, 0, 1, 4'b0001, 4'b0000, 1'b1);
    expect_at("a_3661",        3668, 1, 1, 1, 4'b0001, 4'b0000, 1'b1);
    expect_at("a_clr_start",   3672, 0, 0, 0, 4'b0000, 4'b0000, 1'b1);
    expect_at("a_clr_stays",   3675, 0, 0, 0, 4'b0000, 4'b0000, 1'b1);
    pulse_keys(5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_keys(3670, 1'b1, 1'b1, 1'b0, 1'b0);

    // ch1 countdown from 00:00:02 to expiry
    wait_to(3680);
    bus.CH_SEL  = 2'd1;
    bus.LD_DOWN = 1'b1;
    bus.LD_SEC  = 6'd2;
    expect_at("b_loaded",      3682, 0, 0, 2, 4'b0000, 4'b0000, 1'b1);
    expect_at("b_run",         3683, 0, 0, 2, 4'b0010, 4'b0000, 1'b1);
    expect_at("b_one",         3684, 0, 0, 1, 4'b0010, 4'b0000, 1'b1);
    expect_at("b_expired",     3685, 0, 0, 0, 4'b0000, 4'b0010, 1'b1);
    expect_at("b_done_start",  3692, 0, 0, 0, 4'b0000, 4'b0010, 1'b1);
    expect_at("b_clear",       3702, 0, 0, 0, 4'b0000, 4'b0000, 1'b1);
    expect_at("b_zero_start",  3706, 0, 0, 0, 4'b0000, 4'b0000, 1'b1);
    pulse_keys(3680, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_keys(3681, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_keys(3690, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_keys(3700, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_keys(3703, 1'b1, 1'b0, 1'b0, 1'b0);

    // ch2 saturating load and full-day wrap
    wait_to(3710);
    bus.CH_SEL  = 2'd2;
    bus.LD_DOWN = 1'b0;
    bus.LD_HOUR = 5'd31;
    bus.LD_MIN  = 6'd63;
    bus.LD_SEC  = 6'd63;
    expect_at("c_sat_load",    3712, 23, 59, 59, 4'b0000, 4'b0000, 1'b1);
    expect_at("c_wrap",        3714, 0, 0, 0, 4'b0100, 4'b0000, 1'b1);
    expect_at("c_after_wrap",  3715, 0, 0, 1, 4'b0100, 4'b0000, 1'b1);
    expect_at("c_sat_hour",    3722, 23, 59, 5, 4'b0000, 4'b0000, 1'b1);
    pulse_keys(3710, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_keys(3711, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_to(3720);
    bus.LD_HOUR = 5'd24;
    bus.LD_MIN  = 6'd60;
    bus.LD_SEC  = 6'd5;
    pulse_keys(3720, 1'b0, 1'b0, 1'b1, 1'b0);

    // real-rate ticks on ch0 and lap hold
    wait_to(3730);
    bus.FAST   = 1'b0;
    bus.CH_SEL = 2'd0;
    expect_at("d_pre_tick",    3829, 0, 0, 0, 4'b0001, 4'b0000, 1'b0);
    expect_at("d_tick100",     3830, 0, 0, 0, 4'b0001, 4'b0000, 1'b1);
    expect_at("d_after_tick",  3831, 0, 0, 1, 4'b0001, 4'b0000, 1'b0);
    pulse_keys(3730, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_to(3880);
    expect_at("d_lap_capture", 3881, 0, 0, 1, 4'b0001, 4'b0000, 1'b0);
    expect_at("d_tick200",     3930, 0, 0, 1, 4'b0001, 4'b0000, 1'b1);
    expect_at("d_held",        3980, 0, 0, 1, 4'b0001, 4'b0000, 1'b0);
    expect_at("d_held_late",   3989, 0, 0, 1, 4'b0001, 4'b0000, 1'b0);
    pulse_keys(3880, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_to(3990);
    expect_at("d_release",     3991, 0, 0, 2, 4'b0001, 4'b0000, 1'b0);
    expect_at("d_tick300",     4030, 0, 0, 2, 4'b0001, 4'b0000, 1'b1);
    expect_at("d_live3",       4031, 0, 0, 3, 4'b0001, 4'b0000, 1'b0);
    pulse_keys(3990, 1'b0, 1'b0, 1'b0, 1'b1);

    // two channels running; selection change drops hold
    wait_to(4035);
    bus.CH_SEL = 2'd3;
    expect_at("e_two_run",     4037, 0, 0, 0, 4'b1001, 4'b0000, 1'b0);
    pulse_keys(4035, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_to(4037);
    bus.CH_SEL = 2'd0;
    expect_at("e_hold",        4040, 0, 0, 3, 4'b1001, 4'b0000, 1'b0);
    expect_at("e_hold_late",   4049, 0, 0, 3, 4'b1001, 4'b0000, 1'b0);
    pulse_keys(4038, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_to(4050);
    bus.CH_SEL = 2'd3;
    expect_at("e_sel_ch3",     4051, 0, 0, 0, 4'b1001, 4'b0000, 1'b0);
    expect_at("e_tick400",     4130, 0, 0, 0, 4'b1001, 4'b0000, 1'b1);
    expect_at("e_ch3_one",     4131, 0, 0, 1, 4'b1001, 4'b0000, 1'b0);
    wait_to(4140);
    bus.CH_SEL = 2'd0;
    expect_at("e_back_live",   4141, 0, 0, 4, 4'b1001, 4'b0000, 1'b0);

    // reset mid-run
    wait_to(4150);
    RST = 1'b1;
    expect_at("f_rst",         4151, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
    expect_at("f_rst_after",   4153, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
    wait_to(4151);
    RST = 1'b0;
    wait_to(4152);
    bus.CH_SEL = 2'd2;
    expect_at("f_ch2_zero",    4154, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);

    wait_to(4160);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
